// File: rtl/pixel_path_splitter_pkg.sv
// Shared constants for the pixel path splitter: RGB565 field positions,
// BT.601-style luma weights and the frame-gating FSM encoding.
package pixel_path_splitter_pkg;

    localparam int PIX_W = 16;
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // Weights sum to 256 so a full-scale pixel lands exactly on 255 after >>8.
    localparam logic [7:0] COEF_R = 8'd77;
    localparam logic [7:0] COEF_G = 8'd150;
    localparam logic [7:0] COEF_B = 8'd29;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } state_t;

    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

endpackage

// File: rtl/pixel_path_splitter_if.sv
// Stream bundle around the splitter: one RGB565 input, raw path A, binary path B.
interface pixel_path_splitter_if #(parameter int CNT_W = 20);
    logic               in_sel;
    logic               in_valid;
    logic               in_ready;
    logic               in_sof;
    logic [15:0]        in_data;
    logic               out_a_valid;
    logic               out_a_ready;
    logic [15:0]        out_a_data;
    logic               out_b_valid;
    logic               out_b_ready;
    logic               out_b_data;
    logic               out_sof;
    logic [CNT_W-1:0]   frame_pixels;

    modport slave (
        input  in_sel, in_valid, in_sof, in_data, out_a_ready, out_b_ready,
        output in_ready, out_a_valid, out_a_data, out_b_valid, out_b_data, out_sof, frame_pixels
    );

    modport master (
        output in_sel, in_valid, in_sof, in_data, out_a_ready, out_b_ready,
        input  in_ready, out_a_valid, out_a_data, out_b_valid, out_b_data, out_sof, frame_pixels
    );
endinterface

// File: rtl/pixel_path_splitter_rgb565_to_gray.sv
// Two-stage RGB565 -> 8-bit luma: stage 1 holds the weighted channel products,
// stage 2 holds the summed and scaled gray value. Both stages advance on en.
module rgb565_to_gray
    import pixel_path_splitter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PIX_W-1:0]  pix,
    output logic [7:0]        gray
);

    logic [7:0]  r8, g8, b8;
    logic [15:0] prod_r, prod_g, prod_b;
    logic [15:0] sum;

    assign r8  = expand5(pix[R_MSB:R_LSB]);
    assign g8  = expand6(pix[G_MSB:G_LSB]);
    assign b8  = expand5(pix[B_MSB:B_LSB]);
    assign sum = prod_r + prod_g + prod_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_r <= '0;
            prod_g <= '0;
            prod_b <= '0;
            gray   <= '0;
        end else if (en) begin
            prod_r <= {8'd0, r8} * {8'd0, COEF_R};
            prod_g <= {8'd0, g8} * {8'd0, COEF_G};
            prod_b <= {8'd0, b8} * {8'd0, COEF_B};
            gray   <= sum[15:8];
        end
    end

endmodule

// File: rtl/pixel_path_splitter.sv
// Steers whole RGB565 frames to a raw path (A) or a luma-thresholded binary path (B);
// the path choice is latched only on an accepted start-of-frame beat.
//   state    | meaning
//   WAIT_SOF | after reset: accept and discard everything until a SOF beat arrives
//   RUN      | frame-locked: beats flow through the two-stage pipe with global stall
module pixel_path_splitter
    import pixel_path_splitter_pkg::*;
#(
    parameter logic [7:0] THRESH = 8'd128,
    parameter int         CNT_W  = 20
) (
    input  logic               clk,
    input  logic               rst,
    pixel_path_splitter_if.slave bus
);

    state_t             state_q, state_d;
    logic               in_ready;
    logic               en, accept, take, beat_sel;
    logic               active_sel, seen_sof;
    logic [CNT_W-1:0]   pix_cnt, fp_q;

    logic               s1_valid, s1_sel, s1_sof;
    logic [PIX_W-1:0]   s1_data;
    logic               s2_valid, s2_sel, s2_sof;
    logic [PIX_W-1:0]   s2_data;
    logic [7:0]         gray;

    assign en       = ~s2_valid | (s2_sel ? bus.out_a_ready : bus.out_b_ready);
    assign accept   = bus.in_valid & in_ready;
    assign take     = accept & ((state_q == RUN) | bus.in_sof);
    assign beat_sel = bus.in_sof ? bus.in_sel : active_sel;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            WAIT_SOF: begin
                in_ready = 1'b1;
                if (bus.in_valid && bus.in_sof)
                    state_d = RUN;
            end
            RUN:     in_ready = en;
            default: state_d = WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= WAIT_SOF;
        else     state_q <= state_d;
    end

    // The very first SOF has no completed frame behind it, so frame_pixels keeps its reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_sel <= 1'b1;
            seen_sof   <= 1'b0;
            pix_cnt    <= '0;
            fp_q       <= '0;
        end else if (take) begin
            if (bus.in_sof) begin
                active_sel <= bus.in_sel;
                seen_sof   <= 1'b1;
                pix_cnt    <= CNT_W'(1);
                if (seen_sof)
                    fp_q <= pix_cnt;
            end else if (pix_cnt != '1) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sel   <= 1'b0;
            s1_sof   <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_sel   <= 1'b0;
            s2_sof   <= 1'b0;
            s2_data  <= '0;
        end else if (en) begin
            s1_valid <= take;
            s1_sel   <= beat_sel;
            s1_sof   <= bus.in_sof;
            s1_data  <= bus.in_data;
            s2_valid <= s1_valid;
            s2_sel   <= s1_sel;
            s2_sof   <= s1_sof;
            s2_data  <= s1_data;
        end
    end

    rgb565_to_gray u_gray (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .pix  (bus.in_data),
        .gray (gray)
    );

    assign bus.in_ready     = in_ready;
    assign bus.out_a_valid  = s2_valid & s2_sel;
    assign bus.out_b_valid  = s2_valid & ~s2_sel;
    assign bus.out_a_data   = s2_data;
    assign bus.out_b_data   = s2_valid & ~s2_sel & (gray >= THRESH);
    assign bus.out_sof      = s2_valid & s2_sof;
    assign bus.frame_pixels = fp_q;

endmodule

// File: tb/tb_pixel_path_splitter.sv
// Randomized bench for pixel_path_splitter against a frame-level reference model.
module tb_pixel_path_splitter;
    import pixel_path_splitter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    pixel_path_splitter_if #(.CNT_W(20)) bus();

    pixel_path_splitter #(.THRESH(8'd128), .CNT_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        sel;
        logic [15:0] data;
        logic        bin;
        logic        sof;
        int          acc_cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic lat_strict = 1'b0;
    logic rand_bp    = 1'b0;
    logic ra_force   = 1'b1;
    logic rb_force   = 1'b1;

    // reference model state
    logic m_wait = 1'b1, m_active = 1'b1, m_seen = 1'b0;
    int   m_pix = 0, m_fp = 0;
    logic prev_a_stall = 1'b0, prev_b_stall = 1'b0, prev_sof = 1'b0, prev_b_data = 1'b0;
    logic [15:0] prev_a_data = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_gray(input logic [15:0] p);
        int r, g, b, r8, g8, b8;
        r  = int'(p[15:11]);
        g  = int'(p[10:5]);
        b  = int'(p[4:0]);
        r8 = r * 8 + r / 4;
        g8 = g * 4 + g / 16;
        b8 = b * 8 + b / 4;
        return (77 * r8 + 150 * g8 + 29 * b8) / 256;
    endfunction

    task automatic pop_check(input logic path);
        exp_t e;
        if (q.size() == 0) begin
            check_val("unexpected_out", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            check_val("path", {31'd0, path}, {31'd0, e.sel});
            if (path) check_val("a_data", {16'd0, bus.out_a_data}, {16'd0, e.data});
            else      check_val("b_data", {31'd0, bus.out_b_data}, {31'd0, e.bin});
            check_val("out_sof", {31'd0, bus.out_sof}, {31'd0, e.sof});
            if (lat_strict) check_val("latency", cyc - e.acc_cyc, 32'd2);
        end
    endtask

    // Monitor + reference model, evaluated mid-cycle when everything is settled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                m_wait = 1'b1; m_active = 1'b1; m_seen = 1'b0; m_pix = 0; m_fp = 0;
                prev_a_stall = 1'b0; prev_b_stall = 1'b0;
            end else begin
                check_val("frame_pixels", bus.frame_pixels, m_fp);
                check_val("one_path", {31'd0, bus.out_a_valid & bus.out_b_valid}, 32'd0);
                if (prev_a_stall) begin
                    check_val("a_hold_valid", {31'd0, bus.out_a_valid}, 32'd1);
                    check_val("a_hold_data", {16'd0, bus.out_a_data}, {16'd0, prev_a_data});
                    check_val("a_hold_sof", {31'd0, bus.out_sof}, {31'd0, prev_sof});
                end
                if (prev_b_stall) begin
                    check_val("b_hold_valid", {31'd0, bus.out_b_valid}, 32'd1);
                    check_val("b_hold_data", {31'd0, bus.out_b_data}, {31'd0, prev_b_data});
                    check_val("b_hold_sof", {31'd0, bus.out_sof}, {31'd0, prev_sof});
                end
                if ((bus.out_a_valid && !bus.out_a_ready) || (bus.out_b_valid && !bus.out_b_ready))
                    check_val("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
                if (bus.out_a_valid && bus.out_a_ready) pop_check(1'b1);
                if (bus.out_b_valid && bus.out_b_ready) pop_check(1'b0);
                prev_a_stall = bus.out_a_valid & ~bus.out_a_ready;
                prev_b_stall = bus.out_b_valid & ~bus.out_b_ready;
                prev_a_data  = bus.out_a_data;
                prev_b_data  = bus.out_b_data;
                prev_sof     = bus.out_sof;

                if (bus.in_valid && bus.in_ready && !(m_wait && !bus.in_sof)) begin
                    if (bus.in_sof) begin
                        m_wait   = 1'b0;
                        m_active = bus.in_sel;
                        if (m_seen) m_fp = m_pix;
                        m_seen = 1'b1;
                        m_pix  = 1;
                    end else if (m_pix < (1 << 20) - 1) begin
                        m_pix++;
                    end
                    e.sel     = m_active;
                    e.data    = bus.in_data;
                    e.bin     = (ref_gray(bus.in_data) >= 128);
                    e.sof     = bus.in_sof;
                    e.acc_cyc = cyc;
                    q.push_back(e);
                end
            end
        end
    end

    // Sink ready driver: forced values or random backpressure.
    initial begin
        bus.out_a_ready = 1'b1;
        bus.out_b_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) begin
                bus.out_a_ready = ($urandom_range(0, 3) != 0);
                bus.out_b_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.out_a_ready = ra_force;
                bus.out_b_ready = rb_force;
            end
        end
    end

    task automatic send(input logic sof, input logic [15:0] d, input logic sel);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = d;
        bus.in_sel   = sel;
        @(negedge clk);
        while (!bus.in_ready) begin
            t++;
            if (t > 200) begin
                check_val("send_timeout", 32'd1, 32'd0);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        check_val("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_sel   = 1'b1;
        bus.in_data  = '0;

        repeat (3) @(posedge clk);
        #2;
        check_val("rst_a_valid", {31'd0, bus.out_a_valid}, 32'd0);
        check_val("rst_b_valid", {31'd0, bus.out_b_valid}, 32'd0);
        check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_val("rst_frame_pixels", bus.frame_pixels, 32'd0);
        rst = 1'b0;
        idle(2);

        // 1: pre-SOF beats dropped, first SOF appears on A two clocks later
        lat_strict = 1'b1;
        for (int i = 0; i < 3; i++) send(1'b0, 16'($urandom), 1'b1);
        send(1'b1, 16'hFFFF, 1'b1);
        idle(4);

        // 2: binary frame
        send(1'b1, 16'hFFFF, 1'b0);
        send(1'b0, 16'h0000, 1'b0);
        send(1'b0, 16'hF800, 1'b0);
        idle(4);

        // 3: in_sel toggles mid-frame, then back-to-back A->B switch
        send(1'b1, 16'h1234, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b0, 16'($urandom), i[0]);
        send(1'b1, 16'hFFFF, 1'b0);
        for (int i = 0; i < 3; i++) send(1'b0, 16'($urandom), 1'b1);
        drain();
        lat_strict = 1'b0;

        // 4: path A stalled for 5 clocks during a continuous stream
        send(1'b1, 16'h0001, 1'b1);
        fork
            begin
                for (int i = 0; i < 12; i++) send(1'b0, 16'(i + 2), 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 ra_force = 1'b0;
                repeat (5) @(posedge clk);
                #1 ra_force = 1'b1;
            end
        join
        drain();

        // 5: frame lengths 10 then 7
        send(1'b1, 16'($urandom), 1'b1);
        for (int i = 0; i < 9; i++) send(1'b0, 16'($urandom), 1'b1);
        send(1'b1, 16'($urandom), 1'b0);
        idle(2);
        check_val("fp_10", bus.frame_pixels, 32'd10);
        for (int i = 0; i < 6; i++) send(1'b0, 16'($urandom), 1'b0);
        send(1'b1, 16'($urandom), 1'b1);
        idle(2);
        check_val("fp_7", bus.frame_pixels, 32'd7);
        drain();

        // 6: reset with data in flight
        send(1'b1, 16'hAAAA, 1'b1);
        send(1'b0, 16'h5555, 1'b1);
        send(1'b0, 16'h0F0F, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_val("arst_a_valid", {31'd0, bus.out_a_valid}, 32'd0);
        check_val("arst_b_valid", {31'd0, bus.out_b_valid}, 32'd0);
        check_val("arst_sof", {31'd0, bus.out_sof}, 32'd0);
        check_val("arst_frame_pixels", bus.frame_pixels, 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        idle(1);
        for (int i = 0; i < 4; i++) send(1'b0, 16'($urandom), 1'b0);
        send(1'b1, 16'h07E0, 1'b0);
        send(1'b0, 16'h001F, 1'b0);
        drain();

        // random frames with random backpressure and mid-frame sel noise
        rand_bp = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 12);
            send(1'b1, 16'($urandom), 1'($urandom));
            for (int i = 1; i < len; i++) begin
                send(1'b0, 16'($urandom), 1'($urandom));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rand_bp = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
